// File: rtl/mem_port_arbiter_pkg.sv
// mem_pkg: shared constants and encodings for the two-port memory arbiter.
//   DEPTH / AW / DW : memory geometry (words, address width, data width)
//   state_t         : arbiter FSM encoding
//   P0 / P1         : requester ids, also the encoding of the round-robin pointer
package mem_pkg;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: every signal between the arbiter, its two requesters
// and the single-port memory array.
//   requester side : req/we/addr/wdata in, gnt/ack pulses and rdata out
//   memory side    : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
//   status         : clr in, busy/full out
//   optional       : gcnt0/gcnt1 exist only with MEM_PORT_ARBITER_STATS_EN
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if;
    import mem_pkg::*;

    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata;
    logic          clr;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          full;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0]   gcnt0, gcnt1;
`endif

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr, mem_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
        output gcnt0, gcnt1,
`endif
        output gnt0, gnt1, ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata,
               busy, full
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr, mem_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
        input  gcnt0, gcnt1,
`endif
        input  gnt0, gnt1, ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata,
               busy, full
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin pick.
//   req0, req1 : requests
//   rr         : priority pointer (P0 = port 0 wins a tie)
//   win        : winning port id, meaningful only when any = 1
//   any        : at least one request present
module rr_arb2
    import mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr,
    output logic win,
    output logic any
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            win = rr;
        end else if (req1) begin
            win = P1;
        end else begin
            win = P0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one DEPTH x DW single-port memory between two
// requesters with round-robin arbitration, one access per grant.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requester handshakes, memory port,
//           clr/busy/full status)
// Optional build macro MEM_PORT_ARBITER_STATS_EN adds saturating per-port
// completed-access counters gcnt0/gcnt1 on the interface.
//
// state  | meaning
// IDLE   | waiting for a request; winner captured on leaving
// ACCESS | memory enabled with the captured command (one cycle)
// RESP   | read data returns from memory; ack pulses on leaving
module mem_port_arbiter
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    state_t        state, state_nxt;
    logic          rr;
    logic          win, any;
    logic          cap_id, cap_we;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          gnt0_nxt, gnt1_nxt, ack0_nxt, ack1_nxt;

    logic          gnt0_q, gnt1_q, ack0_q, ack1_q;
    logic [DW-1:0] rdata_q;
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          busy_q, full_q;
    logic [DEPTH-1:0] valid;

    rr_arb2 u_rr_arb2 (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .rr   (rr),
        .win  (win),
        .any  (any)
    );

    assign sel_we    = (win == P1) ? bus.we1    : bus.we0;
    assign sel_addr  = (win == P1) ? bus.addr1  : bus.addr0;
    assign sel_wdata = (win == P1) ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = ACCESS;
                    gnt0_nxt  = (win == P0);
                    gnt1_nxt  = (win == P1);
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
                ack0_nxt  = (cap_id == P0);
                ack1_nxt  = (cap_id == P1);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so that gnt and mem_en
    // appear together in the ACCESS cycle and ack appears with fresh rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            cap_id      <= P0;
            cap_we      <= 1'b0;
            rr          <= P0;
            valid       <= '0;
        end else begin
            gnt0_q   <= gnt0_nxt;
            gnt1_q   <= gnt1_nxt;
            ack0_q   <= ack0_nxt;
            ack1_q   <= ack1_nxt;
            busy_q   <= (state_nxt != IDLE);
            mem_en_q <= (state_nxt == ACCESS);
            mem_we_q <= (state_nxt == ACCESS) && sel_we;

            if (state == IDLE && any) begin
                cap_id      <= win;
                cap_we      <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end

            if (state == RESP) begin
                rr <= ~cap_id;
                if (!cap_we) begin
                    rdata_q <= bus.mem_rdata;
                end
            end

            // clr beats a same-cycle write: the memory is written but the
            // word stays marked invalid.
            if (bus.clr) begin
                valid <= '0;
            end else if (state == ACCESS && cap_we) begin
                valid[mem_addr_q] <= 1'b1;
            end

            full_q <= ~bus.clr & (&valid);
        end
    end

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [15:0] gcnt0_q, gcnt1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (bus.clr) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (ack0_nxt && gcnt0_q != 16'hFFFF) begin
                gcnt0_q <= gcnt0_q + 16'd1;
            end
            if (ack1_nxt && gcnt1_q != 16'hFFFF) begin
                gcnt1_q <= gcnt1_q + 16'd1;
            end
        end
    end

    assign bus.gcnt0 = gcnt0_q;
    assign bus.gcnt1 = gcnt1_q;
`endif

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.full      = full_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a behavioural
// single-port memory, a shadow copy of expected memory contents and a queue
// of expected completions popped at each ack.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    typedef struct packed {
        logic          port;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] shadow [DEPTH];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return bus.gnt0;
            1:       return bus.gnt1;
            2:       return bus.ack0;
            default: return bus.ack1;
        endcase
    endfunction

    task automatic wait_for(input int k, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(k) && n < 10);
    endtask

    task automatic drive(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        if (p == P0) begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
        e.port = p;
        e.we   = w;
        e.data = w ? d : shadow[a];
        sb.push_back(e);
        if (w) shadow[a] = d;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_sb: observed ack with no pending entry, expected none", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_ack_port"}, 32'({bus.ack1, bus.ack0}), e.port ? 32'd2 : 32'd1);
            if (!e.we) check({tag, "_rdata"}, bus.rdata, e.data);
        end
    endtask

    task automatic access(input string tag, input logic p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic clr_at_access);
        int n;
        @(negedge clk);
        drive(p, w, a, d);
        wait_for(p ? 1 : 0, n);
        check({tag, "_gnt_lat"}, 32'(n), 1);
        if (p == P0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        if (clr_at_access) begin
            bus.clr = 1'b1;
            @(negedge clk);
            bus.clr = 1'b0;
            wait_for(p ? 3 : 2, n);
            n++;
        end else begin
            wait_for(p ? 3 : 2, n);
        end
        check({tag, "_ack_lat"}, 32'(n), 2);
        pop_compare(tag);
    endtask

    initial begin
        int n, nacks, ngnt, overlap, last_ack, cyc;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.clr = 0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // reset then idle
        repeat (2) @(negedge clk);
        check("rst_busy_during", 32'(bus.busy), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_flags", 32'({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.mem_en, bus.mem_we,
                                 bus.busy, bus.full}), 0);
        check("idle_rdata", bus.rdata, 0);
        check("idle_mem_addr", 32'(bus.mem_addr), 0);

        // single write then read on port 0
        access("wr5", P0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0);
        access("rd5", P0, 1'b0, 6'd5, 32'h0, 1'b0);
        check("valid5", 32'(dut.valid[5]), 1);
        check("busy_after", 32'(bus.busy), 0);

        // contention from reset release, both ports reading address 5
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        drive(P0, 1'b0, 6'd5, 32'h0);
        drive(P1, 1'b0, 6'd5, 32'h0);
        drive(P0, 1'b0, 6'd5, 32'h0);
        drive(P1, 1'b0, 6'd5, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nacks = 0; ngnt = 0; overlap = 0; last_ack = 0; cyc = 0;
        while (nacks < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt0 && bus.gnt1) overlap++;
            if ((bus.gnt0 || bus.gnt1) && ngnt < sb.size()) begin
                check("cont_gnt_order", 32'(bus.gnt1), 32'(sb[ngnt].port));
                ngnt++;
            end
            if (bus.ack0 || bus.ack1) begin
                if (nacks > 0) check("cont_ack_spacing", 32'(cyc - last_ack), 3);
                last_ack = cyc;
                nacks++;
                ngnt--;
                pop_compare("cont");
                if (nacks == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        check("cont_acks", 32'(nacks), 4);
        check("cont_no_dual_gnt", 32'(overlap), 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (4) @(negedge clk);
        check("cont_idle", 32'(bus.busy), 0);

        // fill every word, alternating ports
        for (int i = 0; i < DEPTH; i++) begin
            access("fill", i[0], 1'b1, AW'(i), $urandom, 1'b0);
            if (i == DEPTH - 2) check("fill_not_full", 32'(bus.full), 0);
            if (i == DEPTH - 1) check("fill_full", 32'(bus.full), 1);
        end
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_full", 32'(bus.full), 0);
        check("clr_valid", 32'(dut.valid != '0), 0);

        // clr colliding with the ACCESS cycle of a write to address 9
        access("coll9", P1, 1'b1, 6'd9, 32'hCAFE0009, 1'b1);
        check("coll9_mem", mem[9], shadow[9]);
        check("coll9_valid", 32'(dut.valid[9]), 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 9) access("refill", i[0], 1'b1, AW'(i), $urandom, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("coll9_not_full", 32'(bus.full), 0);
        access("wr9", P0, 1'b1, 6'd9, 32'h00000099, 1'b0);
        check("wr9_full", 32'(bus.full), 1);

        // reset during ACCESS of a port 1 write, with rr pointing at port 1
        access("pre_rst", P0, 1'b1, 6'd1, 32'h11111111, 1'b0);
        @(negedge clk);
        drive(P1, 1'b1, 6'd2, 32'h22222222);
        wait_for(1, n);
        check("mid_gnt1", 32'(n), 1);
        check("mid_mem_en", 32'(bus.mem_en), 1);
        rst = 1'b0;
        #1;
        check("mid_async_clear", 32'({bus.busy, bus.mem_en, bus.gnt1}), 0);
        bus.req1 = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ack1) n++;
        end
        check("mid_no_ack1", 32'(n), 0);
        check("mid_busy", 32'(bus.busy), 0);
        drive(P0, 1'b1, 6'd3, 32'h33333333);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd4; bus.wdata1 = 32'h44444444;
        wait_for(0, n);
        check("mid_rr0_gnt", 32'({bus.gnt1, bus.gnt0}), 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_for(2, n);
        check("mid_ack_lat", 32'(n), 2);
        pop_compare("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
